simd_lane_sequencer: RTL and testbench

//  Sequences the 10-lane SIMD datapath: on start, walks memory lines 1..LANES, splits each 32-bit

---
 rtl/simd_pkg.sv | 6 +
 rtl/simd_lane_alu.sv | 19 +
 rtl/simd_lane_sequencer.sv | 94 +++++++++
 tb/tb_simd_lane_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: shared opcode, state and width definitions for the SIMD lane sequencer.
package simd_pkg;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {OP_ADD, OP_MAX, OP_XOR, OP_RSVD} op_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/simd_lane_alu.sv
// simd_lane_alu: combinational lane ALU shared by all lanes (add, unsigned max, xor).
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  op_t          opcode,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    output logic [W-1:0] result,
    output logic         carry
);
    logic [W:0] sum;
    assign sum    = {1'b0, hi} + {1'b0, lo};
    assign carry  = (opcode == OP_ADD) && sum[W];
    assign result = (opcode == OP_ADD) ? sum[W-1:0] :
                    (opcode == OP_MAX) ? ((hi >= lo) ? hi : lo) :
                    (opcode == OP_XOR) ? (hi ^ lo) : '0;
endmodule

// File: rtl/simd_lane_sequencer.sv
// simd_lane_sequencer: walks memory lines 1..LANES through one time-shared ALU,
// writing each line's result into its lane register one cycle after the read.
module simd_lane_sequencer
    import simd_pkg::*;
#(
    parameter int LANES  = 10,
    parameter int ADDR_W = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              opcode,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [2*DATA_W-1:0]     mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ovf,
    output logic [LANES*DATA_W-1:0] res_flat
);
    if (LANES > (1 << ADDR_W) - 1) begin : g_lanes_check
        $error("LANES does not fit the lane address range");
    end

    state_t              state, state_d;
    op_t                 op_q;
    logic                accept, last;
    logic                wr_valid;
    logic [ADDR_W-1:0]   wr_idx;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;

    simd_lane_alu #(.W(DATA_W)) u_alu (
        .opcode (op_q),
        .hi     (mem_rdata[2*DATA_W-1:DATA_W]),
        .lo     (mem_rdata[DATA_W-1:0]),
        .result (alu_res),
        .carry  (alu_carry)
    );

    assign last = (mem_addr == ADDR_W'(LANES));
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        unique case (state)
            S_IDLE: begin
                accept  = start;
                state_d = start ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: state_d = last ? S_DRAIN : S_ISSUE;
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_ADD;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            wr_valid  <= 1'b0;
            wr_idx    <= '0;
            res_flat  <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state    <= state_d;
            wr_valid <= mem_rd_en;
            wr_idx   <= mem_addr - 1'b1;
            if (accept) begin
                op_q      <= op_t'(opcode);
                err       <= 1'b0;
                ovf       <= 1'b0;
                mem_rd_en <= 1'b1;
                mem_addr  <= ADDR_W'(1);
            end else if (state == S_ISSUE) begin
                mem_rd_en <= !last;
                mem_addr  <= last ? mem_addr : mem_addr + 1'b1;
            end
            // read data for the address issued last cycle is on mem_rdata now
            if (wr_valid) begin
                res_flat[wr_idx*DATA_W +: DATA_W] <= alu_res;
                if (alu_carry) ovf <= 1'b1;
            end
            if (state == S_DRAIN) err <= (op_q == OP_RSVD);
        end
    end
endmodule

// File: tb/tb_simd_lane_sequencer.sv
// tb_simd_lane_sequencer: directed and randomized passes checked against a lane-by-lane model.
module tb_simd_lane_sequencer;
    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [1:0]   opcode;
    logic         mem_rd_en, busy, done, err, ovf;
    logic [3:0]   mem_addr;
    logic [31:0]  mem_rdata;
    logic [159:0] res_flat;
    logic [31:0]  mem [16];
    logic [3:0]   reads [$];
    int           total = 0, passed = 0, failed = 0;

    always #5 clk = ~clk;

    simd_lane_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .ovf(ovf), .res_flat(res_flat)
    );

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            reads.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, output logic [159:0] r, output bit o, output bit e);
        int hi, lo, v;
        r = '0;
        o = 0;
        e = (op == 2'd3);
        for (int k = 0; k < 10; k++) begin
            hi = int'(mem[k+1][31:16]);
            lo = int'(mem[k+1][15:0]);
            if (op == 2'd0) begin
                v = hi + lo;
                if (v > 65535) o = 1;
            end else if (op == 2'd1) v = (lo > hi) ? lo : hi;
            else if (op == 2'd2) v = hi ^ lo;
            else v = 0;
            r[k*16 +: 16] = v[15:0];
        end
    endtask

    task automatic fill_std();
        for (int a = 0; a < 16; a++) mem[a] = {16'(a * 3), 16'(a)};
    endtask

    task automatic do_pass(input logic [1:0] op, input bit hold, input bit toggle, input string tag);
        int c;
        logic [159:0] er;
        logic [39:0] rd_obs, rd_exp;
        bit eo, ee;
        model(op, er, eo, ee);
        reads.delete();
        start = 1'b1;
        opcode = op;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check({tag, "_cycle1"}, {busy, mem_rd_en, mem_addr, err, ovf}, {1'b1, 1'b1, 4'd1, 1'b0, 1'b0});
                if (!hold) start = 1'b0;
            end
            if (toggle && c == 4) opcode = ~op;
        end while (!done && c < 40);
        check({tag, "_done_cycle"}, c, 12);
        check({tag, "_res"}, res_flat, er);
        check({tag, "_flags"}, {busy, ovf, err}, {1'b1, eo, ee});
        rd_obs = '0;
        rd_exp = '0;
        for (int i = 0; i < 10; i++) begin
            rd_exp[i*4 +: 4] = 4'(i + 1);
            if (i < reads.size()) rd_obs[i*4 +: 4] = reads[i];
        end
        check({tag, "_reads"}, {reads.size(), rd_obs}, {32'd10, rd_exp});
        @(negedge clk);
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [159:0] er;
        bit eo, ee;
        int c;
        rst_n = 1'b0;
        start = 1'b0;
        opcode = 2'd0;
        mem_rdata = '0;
        fill_std();
        repeat (2) @(negedge clk);
        check("reset", {busy, done, err, ovf, mem_rd_en, mem_addr, res_flat}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_pass(2'd0, 0, 0, "add_std");
        check("add_lane0", res_flat[15:0], 16'd4);
        check("add_lane9", res_flat[159:144], 16'd40);

        mem[5] = {16'hFFFF, 16'h0002};
        do_pass(2'd0, 0, 0, "add_carry");
        check("carry_lane4", {res_flat[79:64], ovf}, {16'h0001, 1'b1});
        do_pass(2'd1, 0, 0, "max");
        check("max_lane4", {res_flat[79:64], ovf}, {16'hFFFF, 1'b0});

        for (int a = 0; a < 16; a++) mem[a] = {16'hA5A5, 16'(a)};
        do_pass(2'd2, 0, 0, "xor");
        check("xor_lane0", {res_flat[15:0], err}, {16'hA5A4, 1'b0});

        fill_std();
        do_pass(2'd3, 0, 0, "rsvd");
        check("rsvd_after", {res_flat, err}, {160'd0, 1'b1});
        do_pass(2'd0, 0, 0, "add_after_rsvd");

        do_pass(2'd1, 1, 1, "held_start");
        @(negedge clk);
        check("second_pass_c1", {busy, mem_rd_en, mem_addr}, {1'b1, 1'b1, 4'd1});
        start = 1'b0;
        model(2'd2, er, eo, ee);
        c = 0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("second_pass_res", {c, res_flat}, {32'd11, er});
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            for (int a = 0; a < 16; a++) mem[a] = $urandom;
            do_pass(2'($urandom_range(0, 3)), 0, 0, $sformatf("rand%0d", n));
        end

        fill_std();
        start = 1'b1;
        opcode = 2'd0;
        repeat (6) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort", {busy, mem_rd_en, done, res_flat}, '0);
        rst_n = 1'b1;
        reads.delete();
        c = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) c++;
        end
        check("abort_quiet", {c, reads.size(), busy}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
